// File: rtl/chunked_carry_adder_if.sv
// Operand/result bus for chunked_carry_adder. Optional `sub` port exists only
// when CCA_SUB_MODE_EN is defined.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// the sender holds its payload steady while valid is high and ready is low.
interface chunked_carry_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
`ifdef CCA_SUB_MODE_EN
  logic             sub;

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, S, cout, ovf, out_valid
  );
  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, S, cout, ovf, out_valid
  );
`else
  modport slave (
    input  in_valid, A, B, cin, out_ready,
    output in_ready, S, cout, ovf, out_valid
  );
  modport master (
    output in_valid, A, B, cin, out_ready,
    input  in_ready, S, cout, ovf, out_valid
  );
`endif
endinterface

// File: rtl/chunked_carry_adder.sv
// Multi-cycle adder: adds CHUNK bits per cycle, WIDTH/CHUNK cycles per sum.
// Define CCA_SUB_MODE_EN to add the `sub` input (A + ~B + 1, cin ignored).
module chunked_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_carry_adder_if.slave bus,
  output logic [1:0]           dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0]    K_LAST    = KW'(N - 1);
  localparam logic [WIDTH-1:0] LANE_MASK = WIDTH'({CHUNK{1'b1}});

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sum_sl;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;
  logic             accept;

  assign base    = 32'(k) * 32'(CHUNK);
  assign a_sl    = CHUNK'(a_q >> base);
  assign b_sl    = CHUNK'(b_q >> base);
  assign sum_sl  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
  assign acc_nxt = (acc & ~(LANE_MASK << base)) | (WIDTH'(sum_sl[CHUNK-1:0]) << base);
  assign last    = (k == K_LAST);

  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.A;
            k     <= '0;
            acc   <= '0;
            state <= RUN;
`ifdef CCA_SUB_MODE_EN
            b_q   <= bus.sub ? ~bus.B : bus.B;
            carry <= bus.sub ? 1'b1 : bus.cin;
`else
            b_q   <= bus.B;
            carry <= bus.cin;
`endif
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= sum_sl[CHUNK];
          k     <= k + KW'(1);
          if (last) begin
            // Carry into the MSB is recovered as a^b^s at that bit position.
            s_q    <= acc_nxt;
            cout_q <= sum_sl[CHUNK];
            ovf_q  <= a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum_sl[CHUNK-1] ^ sum_sl[CHUNK];
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/chunked_carry_adder.md
CHUNKED_CARRY_ADDER -- requirements
Module: chunked_carry_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operands A, B, cin are presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port A  input  WIDTH  first operand, unsigned or two's complement.
REQ-008 The block SHALL have port B  input  WIDTH  second operand.
REQ-009 The block SHALL have port cin  input  1  carry-in to bit 0.
REQ-010 The block SHALL have port S  output  WIDTH  registered sum.
REQ-011 The block SHALL have port cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 The block SHALL have port ovf  output  1  registered signed overflow flag.
REQ-013 The block SHALL have port out_valid  output  1  S, cout, ovf hold a new result.
REQ-014 The block SHALL have port out_ready  input  1  consumer takes the result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE with rst_n high; out_valid SHALL be 1 only in DONE.
REQ-016 Accept: on an edge with in_valid && in_ready, A, B, cin SHALL be captured, chunk index k cleared to 0, FSM to RUN; in_valid without in_ready SHALL be ignored.
REQ-017 RUN: each cycle, operand bits [k*CHUNK +: CHUNK] plus the registered carry SHALL be added, the slice written into an internal accumulator, the carry registered, k incremented.
REQ-018 After slice N-1, S, cout and ovf SHALL be loaded from the accumulator and final carry in the same edge, and the FSM SHALL enter DONE; out_valid therefore rises exactly N cycles after the accept edge (N=4 at defaults; N=1 when CHUNK=WIDTH).
REQ-019 Result SHALL equal (A + B + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum; ovf = carry into MSB XOR carry out of MSB.
REQ-020 DONE: S, cout, ovf, out_valid SHALL stay constant while out_ready is 0; on an edge with out_ready 1, FSM SHALL go to IDLE; no new accept in the same cycle.
REQ-021 S, cout, ovf SHALL keep their last result through IDLE and RUN until the next DONE load.
REQ-022 Operand changes on A, B, cin after the accept edge SHALL NOT affect the result in flight.
REQ-023 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-024 With rst_n low at a rising edge: FSM to IDLE, k = 0, internal carry and accumulator = 0, S = 0, cout = 0, ovf = 0, out_valid = 0.
REQ-025 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-026 Reset asserted in RUN or DONE SHALL abandon the transaction with no result produced.

Configuration
REQ-027 With macro CCA_SUB_MODE_EN defined, the block SHALL add port sub input 1, captured at accept; sub=1 SHALL compute A + ~B + 1 with cin ignored (cout=1 means no borrow); sub=0 SHALL behave as REQ-019.
REQ-028 Without CCA_SUB_MODE_EN, port sub SHALL NOT exist and the block SHALL only add.

Verification
REQ-029 Defaults, A=414, B=1036, cin=0 -> S=1450, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-030 A=5045, B=45042, cin=0 -> S=50087, cout=0, ovf=0; A=32768, B=32768 -> S=0, cout=1, ovf=1.
REQ-031 A=65535, B=65535, cin=1 -> S=65535, cout=1, ovf=0; in_ready=0 throughout RUN and DONE.
REQ-032 out_ready held 0 for 3 cycles in DONE -> S, cout, ovf, out_valid unchanged, IDLE on the edge after out_ready=1; A/B toggled during RUN -> result unaffected.
REQ-033 rst_n low for 1 cycle at k=2 of RUN -> S=0, out_valid=0, in_ready=1 next cycle, no stale result emitted.
REQ-034 CCA_SUB_MODE_EN, sub=1: A=1000, B=1001 -> S=65535, cout=0, ovf=0; A=32768, B=1 -> S=32767, cout=1, ovf=1.
